// File: rtl/fp_packer.sv
// fp_packer: multi-cycle normalize / round-to-nearest-even / pack to IEEE-754 binary32.
// Optional subnormal support is enabled with `define FP_PACKER_DENORM_EN; otherwise subnormals flush to zero.
module fp_packer (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        sign_i,
  input  logic [9:0]  exp_i,
  input  logic [27:0] mant_i,
  input  logic        inf_i,
  input  logic        nan_i,
  output logic [31:0] result_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        overflow_o,
  output logic        underflow_o
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic signed [10:0] exp_q, exp_d;
  logic [27:0]        mant_q, mant_d;
  logic [31:0]        result_d;
  logic               valid_d, ovf_d, unf_d;

  // Rounding datapath, only consumed in ROUND (mant_q[27] is always clear there)
  logic               inc, hidden;
  logic [24:0]        sum;
  logic signed [10:0] exp_r;
  logic [22:0]        frac;

  assign inc    = mant_q[2] & ((|mant_q[1:0]) | mant_q[3]);
  assign sum    = {1'b0, mant_q[26:3]} + {24'b0, inc};
  assign exp_r  = sum[24] ? exp_q + 11'sd1 : exp_q;
  assign hidden = sum[24] | sum[23];
  assign frac   = sum[24] ? sum[23:1] : sum[22:0];

  assign ready_o = rst_n_i && (state_q == IDLE);

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    result_d = result_o;
    valid_d  = valid_o;
    ovf_d    = overflow_o;
    unf_d    = underflow_o;
    case (state_q)
      IDLE: if (valid_i && ready_o) begin
        sign_d = sign_i;
        exp_d  = {exp_i[9], exp_i};
        mant_d = mant_i;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        if (nan_i) begin
          result_d = 32'h7FC0_0000;
          valid_d  = 1'b1;
          state_d  = DONE;
        end else if (inf_i) begin
          result_d = {sign_i, 8'hFF, 23'b0};
          valid_d  = 1'b1;
          state_d  = DONE;
        end else begin
          state_d = NORM;
        end
      end
      NORM: begin
        if (mant_q == 28'b0) begin
          result_d = {sign_q, 31'b0};
          unf_d    = 1'b0;
          valid_d  = 1'b1;
          state_d  = DONE;
        end else if (mant_q[27]) begin
          mant_d  = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
          exp_d   = exp_q + 11'sd1;
          state_d = ROUND;
        end else if (exp_q < 11'sd1) begin
`ifdef FP_PACKER_DENORM_EN
          // Far below the subnormal range every bit lands in sticky anyway
          if (exp_q < -11'sd25) begin
            mant_d = {27'b0, |mant_q};
            exp_d  = 11'sd1;
          end else begin
            mant_d = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
            exp_d  = exp_q + 11'sd1;
          end
`else
          result_d = {sign_q, 31'b0};
          unf_d    = 1'b1;
          valid_d  = 1'b1;
          state_d  = DONE;
`endif
        end else if (mant_q[26]) begin
          state_d = ROUND;
        end else if (exp_q > 11'sd1) begin
          mant_d = {mant_q[26:0], 1'b0};
          exp_d  = exp_q - 11'sd1;
        end else begin
`ifdef FP_PACKER_DENORM_EN
          state_d = ROUND;
`else
          result_d = {sign_q, 31'b0};
          unf_d    = 1'b1;
          valid_d  = 1'b1;
          state_d  = DONE;
`endif
        end
      end
      ROUND: begin
        // A subnormal rounding up into the hidden bit picks up field 1 via exp_q==1
        if (hidden && exp_r >= 11'sd255) begin
          result_d = {sign_q, 8'hFF, 23'b0};
          ovf_d    = 1'b1;
        end else begin
          result_d = {sign_q, hidden ? exp_r[7:0] : 8'h00, frac};
          unf_d    = ~hidden;
        end
        valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: if (ready_i) begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      result_o    <= '0;
      valid_o     <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      result_o    <= result_d;
      valid_o     <= valid_d;
      overflow_o  <= ovf_d;
      underflow_o <= unf_d;
    end
  end

endmodule

// File: tb/tb_fp_packer.sv
// Bench for fp_packer: directed cases plus randomized operands against an exact-value RNE reference.
module tb_fp_packer;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        valid_i = 0, ready_o;
  logic        sign_i = 0, inf_i = 0, nan_i = 0;
  logic [9:0]  exp_i = '0;
  logic [27:0] mant_i = '0;
  logic [31:0] result_o;
  logic        valid_o, ready_i = 0, overflow_o, underflow_o;

  int n_cmp = 0, n_err = 0;

  fp_packer dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .sign_i(sign_i), .exp_i(exp_i), .mant_i(mant_i), .inf_i(inf_i), .nan_i(nan_i),
    .result_o(result_o), .valid_o(valid_o), .ready_i(ready_i),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  // Value = m * 2^(e-153); round to nearest even at the binary32 quantum. Returns {ovf,unf,result}.
  function automatic logic [33:0] ref_pack(bit s, int e, bit [27:0] m, bit inf, bit nan);
    int p, ebias, q;
    longint sig, rem, half;
    bit up;
    if (nan) return {2'b00, 32'h7FC0_0000};
    if (inf) return {2'b00, s, 8'hFF, 23'h0};
    if (m == 0) return {2'b00, s, 31'h0};
    p = 27;
    while (!m[p]) p--;
    ebias = e + p - 26;
`ifndef FP_PACKER_DENORM_EN
    if (ebias < 1) return {2'b01, s, 31'h0};
`endif
    q = (ebias >= 1) ? p - 23 : 4 - e;
    if (q <= 0) begin
      sig = longint'(m) << (-q); up = 0;
    end else if (q > 28) begin
      sig = 0; up = 0;
    end else begin
      sig  = longint'(m) >> q;
      rem  = longint'(m) & ((64'sd1 << q) - 1);
      half = 64'sd1 << (q - 1);
      up   = (rem > half) || (rem == half && sig[0]);
    end
    sig = sig + longint'(up);
    if (ebias >= 1) begin
      if (sig == (64'sd1 << 24)) begin sig = 64'sd1 << 23; ebias++; end
      if (ebias >= 255) return {2'b10, s, 8'hFF, 23'h0};
      return {2'b00, s, ebias[7:0], sig[22:0]};
    end
    return {1'b0, !sig[23], s, sig[23] ? 8'd1 : 8'd0, sig[22:0]};
  endfunction

  task automatic run_op(input string tag, input bit s, input logic [9:0] e, input logic [27:0] m,
                        input bit inf, input bit nan, input int hold, output int lat);
    logic [33:0] want;
    bit rdy_hi;
    int k;
    want = ref_pack(s, int'($signed(e)), m, inf, nan);
    k = 0;
    while (!ready_o && k < 50) begin @(posedge clk); #1; k++; end
    chk({tag, "_rdy_idle"}, 32'(ready_o), 32'd1);
    sign_i = s; exp_i = e; mant_i = m; inf_i = inf; nan_i = nan; valid_i = 1;
    @(posedge clk); #1;
    valid_i = 0;
    lat = 1; rdy_hi = 0;
    while (!valid_o && lat < 100) begin
      rdy_hi |= ready_o;
      @(posedge clk); #1; lat++;
    end
    rdy_hi |= ready_o;
    chk({tag, "_valid"}, 32'(valid_o), 32'd1);
    chk({tag, "_rdy_busy"}, 32'(rdy_hi), 32'd0);
    chk({tag, "_result"}, result_o, want[31:0]);
    chk({tag, "_flags"}, {30'b0, overflow_o, underflow_o}, {30'b0, want[33:32]});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_res"}, result_o, want[31:0]);
      chk({tag, "_hold_vld"}, 32'(valid_o), 32'd1);
    end
    ready_i = 1;
    @(posedge clk); #1;
    ready_i = 0;
    chk({tag, "_released"}, 32'(valid_o), 32'd0);
  endtask

  initial begin
    int lat, k;
    bit s, inf, nan, seen;
    logic [9:0] e;
    logic [27:0] m;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", result_o, 32'h0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_flags", {30'b0, overflow_o, underflow_o}, 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd0);
    rst_n = 1;
    #1;
    chk("ready_after_rst", 32'(ready_o), 32'd1);

    run_op("one", 0, 10'd127, 28'h400_0000, 0, 0, 0, lat);
    chk("one_const", result_o, 32'h3F80_0000);
    chk("one_latency", lat, 3);
    run_op("lshift", 0, 10'd130, 28'h0C0_0000, 0, 0, 0, lat);
    chk("lshift_const", result_o, 32'h3FC0_0000);
    run_op("carry", 0, 10'd127, 28'h800_0000, 0, 0, 0, lat);
    chk("carry_const", result_o, 32'h4000_0000);
    run_op("tie_even", 0, 10'd127, 28'h400_0004, 0, 0, 0, lat);
    chk("tie_even_const", result_o, 32'h3F80_0000);
    run_op("tie_odd", 0, 10'd127, 28'h400_000C, 0, 0, 0, lat);
    chk("tie_odd_const", result_o, 32'h3F80_0002);
    run_op("above", 0, 10'd127, 28'h400_0006, 0, 0, 0, lat);
    chk("above_const", result_o, 32'h3F80_0001);
    run_op("ovf_pos", 0, 10'd254, 28'h7FF_FFFC, 0, 0, 0, lat);
    chk("ovf_pos_const", {result_o[31:1], overflow_o}, {31'h3FC0_0000, 1'b1});
    run_op("ovf_neg", 1, 10'd254, 28'h7FF_FFFC, 0, 0, 0, lat);
    chk("ovf_neg_const", result_o, 32'hFF80_0000);
    run_op("nan", 1, 10'd3, 28'h123, 1, 1, 0, lat);
    chk("nan_const", result_o, 32'h7FC0_0000);
    chk("nan_latency", lat, 1);
    run_op("inf", 1, 10'd0, 28'h0, 1, 0, 0, lat);
    chk("inf_const", result_o, 32'hFF80_0000);
    run_op("zero_pos", 0, 10'd50, 28'h0, 0, 0, 0, lat);
    chk("zero_pos_const", result_o, 32'h0000_0000);
    run_op("zero_neg", 1, 10'd50, 28'h0, 0, 0, 0, lat);
    chk("zero_neg_const", result_o, 32'h8000_0000);
    run_op("subn", 0, 10'd1, 28'h200_0000, 0, 0, 0, lat);
`ifdef FP_PACKER_DENORM_EN
    chk("subn_const", result_o, 32'h0040_0000);
`else
    chk("subn_const", result_o, 32'h0000_0000);
`endif
    chk("subn_unf", 32'(underflow_o), 32'd1);
    run_op("hold5", 0, 10'd127, 28'h400_0000, 0, 0, 5, lat);

    // Reset while the unit is deep in left-normalisation
    k = 0;
    while (!ready_o && k < 50) begin @(posedge clk); #1; k++; end
    sign_i = 0; exp_i = 10'd140; mant_i = 28'h1; inf_i = 0; nan_i = 0; valid_i = 1;
    @(posedge clk); #1;
    valid_i = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk); #1;
    chk("midrst_result", result_o, 32'h0);
    chk("midrst_valid", 32'(valid_o), 32'd0);
    chk("midrst_ready", 32'(ready_o), 32'd0);
    rst_n = 1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; seen |= valid_o; end
    chk("midrst_no_result", 32'(seen), 32'd0);
    chk("midrst_idle", 32'(ready_o), 32'd1);

    for (int i = 0; i < 300; i++) begin
      s = 1'($urandom_range(0, 1));
      m = 28'($urandom) >> $urandom_range(0, 27);
      if ($urandom_range(0, 15) == 0) m = '0;
      case ($urandom_range(0, 3))
        0: e = 10'($urandom);
        1: e = 10'($urandom_range(100, 160));
        2: e = 10'($urandom_range(0, 40)) - 10'd20;
        default: e = 10'($urandom_range(230, 260));
      endcase
      if (m[27] && e[9]) e[9] = 1'b0;
      nan = ($urandom_range(0, 19) == 0);
      inf = ($urandom_range(0, 19) == 0);
      run_op("rand", s, e, m, inf, nan, ($urandom_range(0, 7) == 0) ? 2 : 0, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end
endmodule
